alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64, even).
REQ-002 SHALL have parameter ENABLE_MD, default 1; when 0, M-extension ops return 0 with base-op latency.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  5  operation code from shared package.
REQ-008 operand1  input  XLEN  first operand (rs1 / dividend / multiplicand).
REQ-009 operand2  input  XLEN  second operand (rs2 / divisor / multiplier / shift amount).
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  XLEN  registered result.
REQ-013 zero  output  1  registered; high when result == 0.

Function
REQ-014 Base ops, op[4]=0: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9; codes 10-15 SHALL yield 0.
REQ-015 Shift amount SHALL be operand2[$clog2(XLEN)-1:0]; SLT signed, SLTU unsigned compare, result 0/1 zero-extended.
REQ-016 M ops, op[4]=1: MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23; codes 24-31 SHALL yield 0 with base-op latency.
REQ-017 Handshake: transfer occurs when in_valid && in_ready; operands and op captured on that edge; inputs then ignored until next transfer.
REQ-018 in_ready SHALL be high only in state IDLE.
REQ-019 States: IDLE, CALC, FIX, DONE. IDLE->DONE on base-op or illegal-op accept; IDLE->CALC on M-op accept; CALC->FIX after exactly XLEN iteration cycles; FIX->DONE after one cycle; DONE->IDLE when out_ready.
REQ-020 Latency: base op out_valid in cycle after accept; M op out_valid exactly XLEN+2 cycles after accept, independent of operand values.
REQ-021 out_valid high only in DONE; result and zero SHALL hold stable while out_valid && !out_ready.
REQ-022 MUL: iterative shift-add on operand magnitudes, 2*XLEN-bit product; FIX applies sign; MUL returns low XLEN, MULH/MULHSU/MULHU high XLEN with signed*signed, signed*unsigned, unsigned*unsigned.
REQ-023 DIV/REM: restoring division on magnitudes, one quotient bit per CALC cycle; FIX applies sign: quotient negative iff operand signs differ, remainder takes dividend sign.
REQ-024 Divide by zero: quotient all ones (DIV and DIVU), remainder = operand1; no exception.
REQ-025 Signed overflow (operand1 = -2^(XLEN-1), operand2 = -1): DIV returns operand1, REM returns 0.
REQ-026 All arithmetic SHALL wrap modulo 2^XLEN; no flags other than zero.

Reset
REQ-027 While rst high at a clk edge: state=IDLE, out_valid=0, result=0, zero=1, iteration counter=0, internal accumulators=0.
REQ-028 rst asserted mid-CALC/FIX/DONE SHALL abort the operation; in-flight result discarded; in_ready=1 in first cycle after rst deasserts.
REQ-029 in_valid during rst SHALL not be accepted.

Structure
REQ-030 Package alu_mc_pkg SHALL hold the 5-bit op codes, state enum, and is_md(op)/is_signed helpers.
REQ-031 Sub-module alu_md_iter SHALL hold the shift-add/restoring datapath, counter and FIX logic; alu_mc holds handshake, FSM, base ops.

Verification (XLEN=32)
REQ-032 ADD 0xFFFFFFFF+1 -> result 0, zero=1, out_valid 1 cycle after accept.
REQ-033 MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; out_valid exactly 34 cycles after accept.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0, zero=1.
REQ-036 Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-037 rst pulse in cycle 5 of DIVU -> out_valid never rises for it; next ADD 2+3 -> 5 with base latency.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states
// and small decode helpers used by the top and the M-extension datapath.
package alu_mc_pkg;

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_AND    = 5'd2;
   localparam logic [4:0] OP_OR     = 5'd3;
   localparam logic [4:0] OP_XOR    = 5'd4;
   localparam logic [4:0] OP_SLL    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_SLT    = 5'd8;
   localparam logic [4:0] OP_SLTU   = 5'd9;
   localparam logic [4:0] OP_MUL    = 5'd16;
   localparam logic [4:0] OP_MULH   = 5'd17;
   localparam logic [4:0] OP_MULHSU = 5'd18;
   localparam logic [4:0] OP_MULHU  = 5'd19;
   localparam logic [4:0] OP_DIV    = 5'd20;
   localparam logic [4:0] OP_DIVU   = 5'd21;
   localparam logic [4:0] OP_REM    = 5'd22;
   localparam logic [4:0] OP_REMU   = 5'd23;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   // Codes 16..23 are the legal M-extension ops.
   function automatic logic is_md(input logic [4:0] op);
      return op[4] && !op[3];
   endfunction

   function automatic logic is_signed_a(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU)
          || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_MULH)
          || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply (shift-add) and restoring divide on operand
// magnitudes, one bit per CALC cycle; sign is applied in the FIX cycle.
module alu_md_iter
   import alu_mc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            calc,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   output logic            last,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] mb;
   logic [XLEN-1:0] a_raw;
   logic [CW-1:0]   cnt;
   logic [1:0]      sel;
   logic            is_div;
   logic            neg_q;
   logic            neg_r;
   logic            div0;

   logic            sa;
   logic            sb;
   logic [XLEN-1:0] ma;
   logic [XLEN-1:0] mbv;
   logic [XLEN:0]   msum;
   logic [XLEN+1:0] diff;

   function automatic logic [XLEN-1:0] mag(
      input logic [XLEN-1:0] v,
      input logic            s
   );
      return (s && v[XLEN-1]) ? -v : v;
   endfunction

   assign sa   = is_signed_a(op);
   assign sb   = is_signed_b(op);
   assign ma   = mag(operand1, sa);
   assign mbv  = mag(operand2, sb);
   assign last = calc && (cnt == LAST_CNT);

   // hi:lo is the product for MUL and remainder:quotient for DIV.
   assign msum = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
   assign diff = {1'b0, hi, lo[XLEN-1]} - {2'b00, mb};

   always_ff @(posedge clk) begin
      if (rst) begin
         hi     <= '0;
         lo     <= '0;
         mb     <= '0;
         a_raw  <= '0;
         cnt    <= '0;
         sel    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
      end else if (start) begin
         hi     <= '0;
         lo     <= op[2] ? ma : mbv;
         mb     <= op[2] ? mbv : ma;
         a_raw  <= operand1;
         cnt    <= '0;
         sel    <= op[1:0];
         is_div <= op[2];
         neg_q  <= (sa && operand1[XLEN-1]) ^ (sb && operand2[XLEN-1]);
         neg_r  <= sa && operand1[XLEN-1];
         div0   <= (operand2 == '0);
      end else if (calc) begin
         cnt <= cnt + 1'b1;
         if (is_div) begin
            if (!diff[XLEN+1]) begin
               hi <= diff[XLEN-1:0];
               lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
               hi <= {hi[XLEN-2:0], lo[XLEN-1]};
               lo <= {lo[XLEN-2:0], 1'b0};
            end
         end else begin
            hi <= msum[XLEN:1];
            lo <= {msum[0], lo[XLEN-1:1]};
         end
      end
   end

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   q_fix;
   logic [XLEN-1:0]   r_fix;

   always_comb begin
      prod  = neg_q ? -{hi, lo} : {hi, lo};
      q_fix = neg_q ? -lo : lo;
      r_fix = neg_r ? -hi : hi;
      // Divide by zero bypasses sign fixing entirely.
      if (div0) begin
         q_fix = '1;
         r_fix = a_raw;
      end
      if (is_div) begin
         result = sel[1] ? r_fix : q_fix;
      end else if (sel == 2'b00) begin
         result = prod[XLEN-1:0];
      end else begin
         result = prod[2*XLEN-1:XLEN];
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready handshake, control FSM and single-cycle
// base ops; M-extension ops are delegated to alu_md_iter.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int ENABLE_MD = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam int SW = $clog2(XLEN);

   state_t          state;
   state_t          state_nx;
   logic            accept;
   logic            md_op;
   logic            md_last;
   logic [XLEN-1:0] md_res;
   logic [XLEN-1:0] base_res;
   logic [SW-1:0]   sh;

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign md_op     = (ENABLE_MD != 0) && is_md(op);
   assign sh        = operand2[SW-1:0];

   always_comb begin
      base_res = '0;
      case (op)
         OP_ADD:  base_res = operand1 + operand2;
         OP_SUB:  base_res = operand1 - operand2;
         OP_AND:  base_res = operand1 & operand2;
         OP_OR:   base_res = operand1 | operand2;
         OP_XOR:  base_res = operand1 ^ operand2;
         OP_SLL:  base_res = operand1 << sh;
         OP_SRL:  base_res = operand1 >> sh;
         OP_SRA:  base_res = $signed(operand1) >>> sh;
         OP_SLT:  base_res = {{(XLEN-1){1'b0}},
                              $signed(operand1) < $signed(operand2)};
         OP_SLTU: base_res = {{(XLEN-1){1'b0}}, operand1 < operand2};
         default: base_res = '0;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = md_op ? CALC : DONE;
         CALC: if (md_last) state_nx = FIX;
         FIX:  state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         result <= '0;
         zero   <= 1'b1;
      end else begin
         state <= state_nx;
         if (accept && !md_op) begin
            result <= base_res;
            zero   <= (base_res == '0);
         end else if (state == FIX) begin
            result <= md_res;
            zero   <= (md_res == '0);
         end
      end
   end

   alu_md_iter #(
      .XLEN(XLEN)
   ) u_md (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && md_op),
      .calc    (state == CALC),
      .op      (op),
      .operand1(operand1),
      .operand2(operand2),
      .last    (md_last),
      .result  (md_res)
   );

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at XLEN=32: vector table plus handshake,
// back-pressure and mid-operation reset sequences.
module tb_alu_mc;
   import alu_mc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  op = 5'd0;
   logic [31:0] operand1 = '0;
   logic [31:0] operand2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        zero;

   int checks = 0;
   int failures = 0;

   alu_mc #(
      .XLEN(32),
      .ENABLE_MD(1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .operand1 (operand1),
      .operand2 (operand2),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic [7:0]  lat;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [4:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r,
                      input int lat);
      vec_t v;
      v.op  = o;
      v.a   = a;
      v.b   = b;
      v.res = r;
      v.z   = (r == 32'd0);
      v.lat = 8'(lat);
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic do_op(input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r,
                        output logic z, output int lat);
      int n;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
      op = o;
      operand1 = a;
      operand2 = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = OP_SUB;
      operand1 = 32'hA5A5A5A5;
      operand2 = 32'h3C3C3C3C;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
      r = result;
      z = zero;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic        z;
      int          lat;
      logic        seen;

      add(OP_ADD,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
      add(OP_SUB,    32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1);
      add(OP_AND,    32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1);
      add(OP_OR,     32'h12340000, 32'h00005678, 32'h12345678, 1);
      add(OP_XOR,    32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1);
      add(OP_SLL,    32'h00000001, 32'h00000021, 32'h00000002, 1);
      add(OP_SRL,    32'h80000000, 32'h00000004, 32'h08000000, 1);
      add(OP_SRA,    32'h80000000, 32'h00000004, 32'hF8000000, 1);
      add(OP_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
      add(OP_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
      add(5'd10,     32'h00000003, 32'h00000004, 32'h00000000, 1);
      add(OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
      add(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34);
      add(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
      add(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
      add(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34);
      add(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34);
      add(OP_DIVU,   32'h00000007, 32'h00000000, 32'hFFFFFFFF, 34);
      add(OP_REMU,   32'h00000007, 32'h00000000, 32'h00000007, 34);
      add(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
      add(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34);
      add(OP_DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 34);
      add(OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 34);
      add(OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 34);
      add(OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 34);
      add(5'd24,     32'h00000009, 32'h00000003, 32'h00000000, 1);

      // Reset with a request pending: nothing may be accepted.
      rst = 1'b1;
      in_valid = 1'b1;
      op = OP_ADD;
      operand1 = 32'd1;
      operand2 = 32'd1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_zero", 64'(zero), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);

      for (int i = 0; i < vq.size(); i++) begin
         do_op(vq[i].op, vq[i].a, vq[i].b, r, z, lat);
         chk($sformatf("vec%0d_op%0d_res", i, vq[i].op),
             64'(r), 64'(vq[i].res));
         chk($sformatf("vec%0d_op%0d_zero", i, vq[i].op),
             64'(z), 64'(vq[i].z));
         chk($sformatf("vec%0d_op%0d_lat", i, vq[i].op),
             64'(lat), 64'(vq[i].lat));
      end

      // Back-pressure: DONE held for 10 cycles with a competing request.
      @(negedge clk);
      while (!in_ready) @(negedge clk);
      out_ready = 1'b0;
      op = OP_ADD;
      operand1 = 32'd2;
      operand2 = 32'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      op = OP_SUB;
      operand1 = 32'd9;
      operand2 = 32'd4;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("hold%0d_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("hold%0d_result", i), 64'(result), 64'd5);
         chk($sformatf("hold%0d_in_ready", i), 64'(in_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release_out_valid", 64'(out_valid), 64'd0);
      chk("release_in_ready", 64'(in_ready), 64'd1);
      chk("release_result", 64'(result), 64'd5);

      // Reset in the fifth cycle of a DIVU aborts it.
      @(negedge clk);
      op = OP_DIVU;
      operand1 = 32'd100;
      operand2 = 32'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_valid", 64'(seen), 64'd0);
      do_op(OP_ADD, 32'd2, 32'd3, r, z, lat);
      chk("abort_add_res", 64'(r), 64'd5);
      chk("abort_add_lat", 64'(lat), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
